// File: rtl/mips_stage_mem.sv
// -----------------------------------------------------------------------------
// mips_stage_mem
//
// MIPS pipeline MEM stage. Takes the EX/MEM bundle and produces the MEM/WB
// bundle. Executes lb/lbu/lh/lhu/lw/sb/sh/sw against an external data memory
// using a req/ack handshake. While an access is in flight, the pipeline is
// held through `stall`. Non-memory instructions pass straight through with no
// stall.
//
// Parameters
//   DELAYED   1: MEM/WB bundle registered; 0: combinational (FSM stays registered)
//   MAX_WAIT  ACCESS cycles without mem_ack before a bus error; 0 = no timeout
//   CTRL_W    width of the pipeline control word
//             (bit 0 = regWrite, bit 1 = memWrite)
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   ex_mem_*             EX/MEM bundle: instruction, pc_addr, control,
//                        reg_port2 (store data), alu_result (address)
//   mem_wb_*             MEM/WB bundle: instruction, pc_addr, control,
//                        alu_result, mem_data
//   stall                hold EX/MEM and all upstream stages this cycle
//   mem_req              access request, held until mem_ack
//   mem_we               1 = store, 0 = load (valid while mem_req)
//   mem_addr             word-aligned address
//   mem_byte_en          byte lanes, little-endian (lane 0 = bits 7:0)
//   mem_wdata            store data replicated onto the selected lanes
//   mem_rdata            load data, sampled in the cycle mem_ack = 1
//   mem_ack              access complete (ignored outside ACCESS)
//   bus_error            one-cycle pulse on timeout / misaligned access
//
// Optional feature
//   MIPS_STAGE_MEM_ALIGN_CHECK_EN defined:
//     - A misaligned half/word access issues no request.
//     - The FSM goes IDLE -> DONE.
//     - bus_error pulses.
//     - regWrite/memWrite are cleared in the MEM/WB control word.
//     - mem_data is forced to 0.
// -----------------------------------------------------------------------------
module mips_stage_mem #(
  parameter int DELAYED  = 1,
  parameter int MAX_WAIT = 16,
  parameter int CTRL_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       ex_mem_instruction,
  input  logic [31:0]       ex_mem_pc_addr,
  input  logic [CTRL_W-1:0] ex_mem_control,
  input  logic [31:0]       ex_mem_reg_port2,
  input  logic [31:0]       ex_mem_alu_result,
  output logic [31:0]       mem_wb_instruction,
  output logic [31:0]       mem_wb_pc_addr,
  output logic [CTRL_W-1:0] mem_wb_control,
  output logic [31:0]       mem_wb_alu_result,
  output logic [31:0]       mem_wb_mem_data,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [3:0]        mem_byte_en,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              bus_error
);

  localparam int CTRL_REG_WRITE = 0;
  localparam int CTRL_MEM_WRITE = 1;
  localparam int CNT_W = $clog2(MAX_WAIT + 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [5:0]       opcode;
  logic [1:0]       op_size;
  logic [1:0]       addr_lo;
  logic             op_unsigned;
  logic             op_store;
  logic             is_mem;
  logic             misalign;
  logic             timeout;
  logic [CNT_W-1:0] wait_cnt_p1;
  logic             zero_data_p1;
  logic             kill_p1;
  logic [1:0]       size_p1;
  logic [1:0]       lo_p1;
  logic             uns_p1;
  logic             store_p1;
  logic [31:0]      rdata_p1;

  logic [31:0]       wb_instruction_nxt;
  logic [31:0]       wb_pc_addr_nxt;
  logic [CTRL_W-1:0] wb_control_nxt;
  logic [31:0]       wb_alu_result_nxt;
  logic [31:0]       wb_mem_data_nxt;

  // Byte lanes touched by an access of the given size at the given offset.
  function automatic logic [3:0] lane_enable(input logic [1:0] sz, input logic [1:0] lo);
    logic [3:0] be;
    case (sz)
      2'b00:   be = 4'b0001 << lo;
      2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // The memory picks the lanes via byte enables, so data is replicated.
  function automatic logic [31:0] store_replicate(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] r;
    case (sz)
      2'b00:   r = {4{d[7:0]}};
      2'b01:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  // Lane select followed by sign or zero extension.
  function automatic logic [31:0] load_extract(input logic [1:0] sz, input logic uns,
                                               input logic [1:0] lo, input logic [31:0] d);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    case (lo)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = lo[1] ? d[31:16] : d[15:0];
    case (sz)
      2'b00:   r = uns ? {24'd0, b} : 32'(b);
      2'b01:   r = uns ? {16'd0, h} : 32'(h);
      default: r = d;
    endcase
    return r;
  endfunction

  assign opcode      = ex_mem_instruction[31:26];
  assign op_size     = opcode[1:0];
  assign op_unsigned = opcode[2];
  assign op_store    = opcode[3];
  assign addr_lo     = ex_mem_alu_result[1:0];

  always_comb begin
    case (opcode)
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B: is_mem = 1'b1;
      default:                                                 is_mem = 1'b0;
    endcase
  end

`ifdef MIPS_STAGE_MEM_ALIGN_CHECK_EN
  assign misalign = is_mem && (((op_size == 2'b01) && addr_lo[0]) ||
                               ((op_size == 2'b11) && (addr_lo != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  // memAck takes priority over the timeout in the same cycle.
  assign timeout = (MAX_WAIT > 0) && !mem_ack && (wait_cnt_p1 == CNT_LAST);

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      S_IDLE: begin
        if (is_mem) begin
          stall     = 1'b1;
          state_nxt = misalign ? S_DONE : S_ACCESS;
        end
      end
      S_ACCESS: begin
        stall = 1'b1;
        if (mem_ack || timeout) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---- stage boundary: request / control registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_byte_en  <= 4'b0000;
      bus_error    <= 1'b0;
      wait_cnt_p1  <= '0;
      zero_data_p1 <= 1'b0;
      kill_p1      <= 1'b0;
    end else begin
      state     <= state_nxt;
      bus_error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (is_mem) begin
            wait_cnt_p1  <= '0;
            zero_data_p1 <= misalign;
            kill_p1      <= misalign;
            bus_error    <= misalign;
            if (!misalign) begin
              mem_req     <= 1'b1;
              mem_we      <= op_store;
              mem_byte_en <= lane_enable(op_size, addr_lo);
            end
          end
        end
        S_ACCESS: begin
          if (MAX_WAIT > 0) wait_cnt_p1 <= wait_cnt_p1 + 1'b1;
          if (mem_ack || timeout) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_byte_en <= 4'b0000;
          end
          if (timeout) begin
            bus_error    <= 1'b1;
            zero_data_p1 <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---- stage boundary: access datapath registers ----
  always_ff @(posedge clk) begin
    if ((state == S_IDLE) && is_mem) begin
      mem_addr  <= {ex_mem_alu_result[31:2], 2'b00};
      mem_wdata <= store_replicate(op_size, ex_mem_reg_port2);
      size_p1   <= op_size;
      lo_p1     <= addr_lo;
      uns_p1    <= op_unsigned;
      store_p1  <= op_store;
    end
    if ((state == S_ACCESS) && mem_ack) rdata_p1 <= mem_rdata;
  end

  // While stalled the EX/MEM bundle is held, so it is still valid in DONE.
  // Cycles that do not retire an instruction send a NOP bubble downstream.
  always_comb begin
    wb_instruction_nxt = '0;
    wb_pc_addr_nxt     = '0;
    wb_control_nxt     = '0;
    wb_alu_result_nxt  = '0;
    wb_mem_data_nxt    = '0;
    if (((state == S_IDLE) && !is_mem) || (state == S_DONE)) begin
      wb_instruction_nxt = ex_mem_instruction;
      wb_pc_addr_nxt     = ex_mem_pc_addr;
      wb_control_nxt     = ex_mem_control;
      wb_alu_result_nxt  = ex_mem_alu_result;
    end
    if (state == S_DONE) begin
      if (kill_p1) begin
        wb_control_nxt[CTRL_REG_WRITE] = 1'b0;
        wb_control_nxt[CTRL_MEM_WRITE] = 1'b0;
      end
      if (!zero_data_p1 && !store_p1)
        wb_mem_data_nxt = load_extract(size_p1, uns_p1, lo_p1, rdata_p1);
    end
  end

  // ---- stage boundary: MEM/WB bundle ----
  if (DELAYED != 0) begin : g_wb_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem_wb_instruction <= '0;
        mem_wb_pc_addr     <= '0;
        mem_wb_control     <= '0;
        mem_wb_alu_result  <= '0;
        mem_wb_mem_data    <= '0;
      end else begin
        mem_wb_instruction <= wb_instruction_nxt;
        mem_wb_pc_addr     <= wb_pc_addr_nxt;
        mem_wb_control     <= wb_control_nxt;
        mem_wb_alu_result  <= wb_alu_result_nxt;
        mem_wb_mem_data    <= wb_mem_data_nxt;
      end
    end
  end else begin : g_wb_comb
    assign mem_wb_instruction = wb_instruction_nxt;
    assign mem_wb_pc_addr     = wb_pc_addr_nxt;
    assign mem_wb_control     = wb_control_nxt;
    assign mem_wb_alu_result  = wb_alu_result_nxt;
    assign mem_wb_mem_data    = wb_mem_data_nxt;
  end

endmodule

// File: tb/tb_mips_stage_mem.sv
// -----------------------------------------------------------------------------
// tb_mips_stage_mem
//
// Directed-vector bench for mips_stage_mem (default parameters). Inputs change
// 1 time unit after the rising edge. Outputs are sampled on the falling edge.
// A small memory responder raises mem_ack after a programmed number of
// request cycles.
// -----------------------------------------------------------------------------
module tb_mips_stage_mem;

  localparam int CTRL_W = 8;
  localparam logic [5:0] OP_LB  = 6'h20, OP_LH  = 6'h21, OP_LW  = 6'h23,
                         OP_LBU = 6'h24, OP_LHU = 6'h25, OP_SB  = 6'h28,
                         OP_SH  = 6'h29, OP_SW  = 6'h2B;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [31:0]       ex_mem_instruction, ex_mem_pc_addr, ex_mem_reg_port2, ex_mem_alu_result;
  logic [CTRL_W-1:0] ex_mem_control;
  logic [31:0]       mem_wb_instruction, mem_wb_pc_addr, mem_wb_alu_result, mem_wb_mem_data;
  logic [CTRL_W-1:0] mem_wb_control;
  logic              stall, mem_req, mem_we, mem_ack, bus_error;
  logic [31:0]       mem_addr, mem_wdata, mem_rdata;
  logic [3:0]        mem_byte_en;

  int n_vec = 0;
  int n_err = 0;

  // results of the last run_mem call
  int          r_req, r_stall, r_berr;
  logic        r_hang, r_we;
  logic [3:0]  r_be;
  logic [31:0] r_addr, r_wd, r_md, r_instr, r_pc;
  logic [CTRL_W-1:0] r_ctl;

  mips_stage_mem #(.DELAYED(1), .MAX_WAIT(16), .CTRL_W(CTRL_W)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .ex_mem_instruction (ex_mem_instruction),
    .ex_mem_pc_addr     (ex_mem_pc_addr),
    .ex_mem_control     (ex_mem_control),
    .ex_mem_reg_port2   (ex_mem_reg_port2),
    .ex_mem_alu_result  (ex_mem_alu_result),
    .mem_wb_instruction (mem_wb_instruction),
    .mem_wb_pc_addr     (mem_wb_pc_addr),
    .mem_wb_control     (mem_wb_control),
    .mem_wb_alu_result  (mem_wb_alu_result),
    .mem_wb_mem_data    (mem_wb_mem_data),
    .stall              (stall),
    .mem_req            (mem_req),
    .mem_we             (mem_we),
    .mem_addr           (mem_addr),
    .mem_byte_en        (mem_byte_en),
    .mem_wdata          (mem_wdata),
    .mem_rdata          (mem_rdata),
    .mem_ack            (mem_ack),
    .bus_error          (bus_error)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_nop();
    ex_mem_instruction = 32'h0;
    ex_mem_pc_addr     = 32'h0;
    ex_mem_control     = '0;
    ex_mem_reg_port2   = 32'h0;
    ex_mem_alu_result  = 32'h0;
  endtask

  // Called at rising edge + 1. Presents one memory instruction and holds it
  // while stall is high. ack_after = number of request cycles without ack
  // (-1: never ack). The task returns at rising edge + 1 with a NOP driven.
  task automatic run_mem(input logic [5:0] op, input logic [31:0] addr,
                         input logic [31:0] sdata, input int ack_after,
                         input logic [31:0] rdata);
    int  cyc;
    bit  done;
    r_req = 0; r_stall = 0; r_berr = 0;
    r_be = 4'h0; r_addr = 32'h0; r_we = 1'b0; r_wd = 32'h0;
    ex_mem_instruction = {op, 26'h0A50010};
    ex_mem_pc_addr     = 32'h0000_0400;
    ex_mem_control     = 8'h03;
    ex_mem_reg_port2   = sdata;
    ex_mem_alu_result  = addr;
    mem_ack            = 1'b0;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 64) begin
      @(negedge clk);
      cyc++;
      if (bus_error) r_berr++;
      if (mem_req) begin
        r_req++;
        r_be = mem_byte_en; r_addr = mem_addr; r_we = mem_we; r_wd = mem_wdata;
      end
      if (stall) r_stall++;
      else       done = 1'b1;
      mem_ack   = mem_req && (ack_after >= 0) && (r_req > ack_after);
      mem_rdata = mem_ack ? rdata : 32'h0BAD_0BAD;
    end
    r_hang = !done;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    drive_nop();
    @(negedge clk);
    if (bus_error) r_berr++;
    r_md = mem_wb_mem_data; r_ctl = mem_wb_control;
    r_instr = mem_wb_instruction; r_pc = mem_wb_pc_addr;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    drive_nop();

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_req",    32'(mem_req), 0);
    check_val("rst_we",     32'(mem_we), 0);
    check_val("rst_be",     32'(mem_byte_en), 0);
    check_val("rst_berr",   32'(bus_error), 0);
    check_val("rst_wb_ins", mem_wb_instruction, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // non-memory pass-through: addu then sub
    ex_mem_instruction = 32'h0022_1821; ex_mem_pc_addr = 32'h1000;
    ex_mem_alu_result = 32'h30; ex_mem_control = 8'h01; ex_mem_reg_port2 = 32'h77;
    @(negedge clk);
    check_val("addu_stall", 32'(stall), 0);
    @(posedge clk); #1;
    ex_mem_instruction = 32'h0022_2022; ex_mem_pc_addr = 32'h1004;
    ex_mem_alu_result = 32'hFFFF_FFF0;
    @(negedge clk);
    check_val("sub_stall",   32'(stall), 0);
    check_val("addu_wb_ins", mem_wb_instruction, 32'h0022_1821);
    check_val("addu_wb_pc",  mem_wb_pc_addr, 32'h1000);
    check_val("addu_wb_alu", mem_wb_alu_result, 32'h30);
    check_val("addu_wb_ctl", 32'(mem_wb_control), 32'h01);
    check_val("addu_wb_md",  mem_wb_mem_data, 0);
    @(posedge clk); #1;
    drive_nop();
    @(negedge clk);
    check_val("sub_wb_ins", mem_wb_instruction, 32'h0022_2022);
    check_val("sub_wb_alu", mem_wb_alu_result, 32'hFFFF_FFF0);

    // async reset clears a non-NOP MEM/WB bundle immediately
    #1 rst_n = 1'b0;
    #1;
    check_val("arst_wb_ins", mem_wb_instruction, 0);
    check_val("arst_wb_alu", mem_wb_alu_result, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // mem_ack outside ACCESS is ignored
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check_val("stray_ack_req",   32'(mem_req), 0);
    check_val("stray_ack_stall", 32'(stall), 0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    check_val("stray_ack_req2", 32'(mem_req), 0);
    check_val("stray_ack_md",   mem_wb_mem_data, 0);
    @(posedge clk); #1;

    // sw 0xDEADBEEF @0x100, ack in first ACCESS cycle
    run_mem(OP_SW, 32'h100, 32'hDEAD_BEEF, 0, 32'h0);
    check_val("sw_hang",  32'(r_hang), 0);
    check_val("sw_req",   r_req, 1);
    check_val("sw_stall", r_stall, 2);
    check_val("sw_we",    32'(r_we), 1);
    check_val("sw_be",    32'(r_be), 32'hF);
    check_val("sw_addr",  r_addr, 32'h100);
    check_val("sw_wd",    r_wd, 32'hDEAD_BEEF);
    check_val("sw_berr",  r_berr, 0);
    check_val("sw_md",    r_md, 0);

    // lb / lbu @0x103 with 0x80FFFFFF
    run_mem(OP_LB, 32'h103, 32'h0, 0, 32'h80FF_FFFF);
    check_val("lb_be",    32'(r_be), 32'h8);
    check_val("lb_we",    32'(r_we), 0);
    check_val("lb_addr",  r_addr, 32'h100);
    check_val("lb_md",    r_md, 32'hFFFF_FF80);
    check_val("lb_ins",   r_instr, {OP_LB, 26'h0A50010});
    check_val("lb_pc",    r_pc, 32'h400);
    run_mem(OP_LBU, 32'h103, 32'h0, 0, 32'h80FF_FFFF);
    check_val("lbu_md",   r_md, 32'h0000_0080);

    // lhu @0x102, ack after 5 waiting cycles
    run_mem(OP_LHU, 32'h102, 32'h0, 5, 32'hBEEF_1234);
    check_val("lhu_req",   r_req, 6);
    check_val("lhu_stall", r_stall, 7);
    check_val("lhu_be",    32'(r_be), 32'hC);
    check_val("lhu_md",    r_md, 32'h0000_BEEF);

    // lh sign extension from the low half, low address bit ignored
    run_mem(OP_LH, 32'h101, 32'h0, 0, 32'h1234_8001);
    check_val("lh_be", 32'(r_be), 32'h3);
    check_val("lh_md", r_md, 32'hFFFF_8001);

    // sh / sb lane replication
    run_mem(OP_SH, 32'h102, 32'h0000_ABCD, 0, 32'h0);
    check_val("sh_be", 32'(r_be), 32'hC);
    check_val("sh_wd", r_wd, 32'hABCD_ABCD);
    run_mem(OP_SB, 32'h101, 32'h0000_005A, 0, 32'h0);
    check_val("sb_be", 32'(r_be), 32'h2);
    check_val("sb_wd", r_wd, 32'h5A5A_5A5A);

    // lw ignores low address bits
    run_mem(OP_LW, 32'h103, 32'h0, 0, 32'h1122_3344);
    check_val("lw_addr", r_addr, 32'h100);
    check_val("lw_be",   32'(r_be), 32'hF);
    check_val("lw_md",   r_md, 32'h1122_3344);

    // lw with no ack -> timeout after 16 request cycles
    run_mem(OP_LW, 32'h180, 32'h0, -1, 32'h0);
    check_val("to_hang",  32'(r_hang), 0);
    check_val("to_req",   r_req, 16);
    check_val("to_stall", r_stall, 17);
    check_val("to_berr",  r_berr, 1);
    check_val("to_md",    r_md, 0);
    check_val("to_reqlo", 32'(mem_req), 0);

    // ack in the timeout cycle: ack wins
    run_mem(OP_LW, 32'h184, 32'h0, 15, 32'h5566_7788);
    check_val("ackto_req",  r_req, 16);
    check_val("ackto_berr", r_berr, 0);
    check_val("ackto_md",   r_md, 32'h5566_7788);

    // async reset asserted during ACCESS
    ex_mem_instruction = {OP_LW, 26'h0A50010}; ex_mem_alu_result = 32'h200;
    ex_mem_control = 8'h03; mem_ack = 1'b0;
    @(negedge clk);
    check_val("racc_idle_stall", 32'(stall), 1);
    @(negedge clk);
    check_val("racc_req_pre", 32'(mem_req), 1);
    #1 rst_n = 1'b0;
    #1;
    check_val("racc_req",  32'(mem_req), 0);
    check_val("racc_be",   32'(mem_byte_en), 0);
    check_val("racc_wbct", 32'(mem_wb_control), 0);
    drive_nop();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_val("racc_post_stall", 32'(stall), 0);
    check_val("racc_post_req",   32'(mem_req), 0);
    @(posedge clk); #1;
    run_mem(OP_LW, 32'h204, 32'h0, 0, 32'hCAFE_0001);
    check_val("racc_lw_req",   r_req, 1);
    check_val("racc_lw_stall", r_stall, 2);
    check_val("racc_lw_md",    r_md, 32'hCAFE_0001);

`ifdef MIPS_STAGE_MEM_ALIGN_CHECK_EN
    // misaligned lw @0x101
    run_mem(OP_LW, 32'h101, 32'h0, 0, 32'h1234_5678);
    check_val("mis_req",   r_req, 0);
    check_val("mis_stall", r_stall, 1);
    check_val("mis_berr",  r_berr, 1);
    check_val("mis_regwr", 32'(r_ctl[0]), 0);
    check_val("mis_md",    r_md, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
